// File: rtl/hazard_ctrl.sv
// Y86-64 pipeline hazard controller: load-use, mispredict, counted ret stalls, sticky halt.
// Optional HAZ_PERF_CNT_EN adds free-running stall/bubble performance counters.
module hazard_ctrl #(
    parameter int ICODE_W          = 4,
    parameter int REG_W            = 4,
    parameter int STAT_W           = 4,
    parameter int RET_STALL_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic               e_Cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    output logic               F_stall,
    output logic               D_stall,
    output logic               W_stall,
    output logic               D_bubble,
    output logic               E_bubble,
    output logic               M_bubble,
    output logic               set_cc,
    output logic               halted,
    output logic [STAT_W-1:0]  stat_latched
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);

    localparam logic [ICODE_W-1:0] IC_MRMOVQ = ICODE_W'(5);
    localparam logic [ICODE_W-1:0] IC_OPQ    = ICODE_W'(6);
    localparam logic [ICODE_W-1:0] IC_JXX    = ICODE_W'(7);
    localparam logic [ICODE_W-1:0] IC_RET    = ICODE_W'(9);
    localparam logic [ICODE_W-1:0] IC_POPQ   = ICODE_W'(11);
    localparam logic [REG_W-1:0]   RNONE     = '1;
    localparam logic [STAT_W-1:0]  STAT_AOK  = STAT_W'(1);
    localparam logic [3:0]         RET_LOAD  = 4'(RET_STALL_CYCLES);

    typedef enum logic {RET_IDLE, RET_WAIT} ret_state_t;
    typedef enum logic {ST_RUN, ST_HALTED} stat_state_t;

    ret_state_t        r_ret_state, w_ret_state_next;
    logic [3:0]        r_ret_cnt, w_ret_cnt_next;
    stat_state_t       r_stat_state, w_stat_state_next;
    logic [STAT_W-1:0] r_stat_latched, w_stat_latched_next;

    logic [REG_W-1:0]  w_src [2];
    logic [1:0]        w_src_hit;
    logic              w_load_use;
    logic              w_mispred;
    logic              w_ret_in_d;
    logic              w_ret_wait;
    logic              w_w_exc;
    logic              w_m_exc;

    // M_icode is kept on the interface; ret tracking no longer decodes it.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, M_icode};

    assign w_src[0] = d_srcA;
    assign w_src[1] = d_srcB;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign w_src_hit[gi] = (E_dstM == w_src[gi]);
        end
    endgenerate

    // RNONE on E_dstM means no load result, so it can never create a dependency.
    assign w_load_use = ((E_icode == IC_MRMOVQ) || (E_icode == IC_POPQ))
                        && (E_dstM != RNONE) && (|w_src_hit);
    assign w_mispred  = (E_icode == IC_JXX) && !e_Cnd;
    assign w_ret_in_d = (D_icode == IC_RET);
    assign w_ret_wait = (r_ret_state == RET_WAIT);
    assign w_w_exc    = (W_stat != STAT_AOK);
    assign w_m_exc    = (m_stat != STAT_AOK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ret_state    <= RET_IDLE;
            r_ret_cnt      <= 4'd0;
            r_stat_state   <= ST_RUN;
            r_stat_latched <= STAT_AOK;
        end else begin
            r_ret_state    <= w_ret_state_next;
            r_ret_cnt      <= w_ret_cnt_next;
            r_stat_state   <= w_stat_state_next;
            r_stat_latched <= w_stat_latched_next;
        end
    end

    // Next-state logic; both FSMs hold while halted.
    always_comb begin
        w_ret_state_next    = r_ret_state;
        w_ret_cnt_next      = r_ret_cnt;
        w_stat_state_next   = r_stat_state;
        w_stat_latched_next = r_stat_latched;
        if (r_stat_state == ST_RUN) begin
            if (w_w_exc) begin
                w_stat_state_next   = ST_HALTED;
                w_stat_latched_next = W_stat;
            end
            case (r_ret_state)
                RET_IDLE: begin
                    if (w_ret_in_d && !w_mispred && !w_load_use) begin
                        w_ret_state_next = RET_WAIT;
                        w_ret_cnt_next   = RET_LOAD;
                    end
                end
                RET_WAIT: begin
                    // The cycle holding count 1 is the last stall cycle.
                    if (r_ret_cnt <= 4'd1) begin
                        w_ret_state_next = RET_IDLE;
                        w_ret_cnt_next   = 4'd0;
                    end else begin
                        w_ret_cnt_next = r_ret_cnt - 4'd1;
                    end
                end
                default: begin
                    w_ret_state_next = RET_IDLE;
                    w_ret_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        W_stall      = 1'b0;
        D_bubble     = 1'b0;
        E_bubble     = 1'b0;
        M_bubble     = 1'b0;
        set_cc       = 1'b0;
        halted       = 1'b0;
        stat_latched = '0;
        if (!rst_n) begin
            F_stall = 1'b0;
        end else if (r_stat_state == ST_HALTED) begin
            F_stall      = 1'b1;
            D_stall      = 1'b1;
            W_stall      = 1'b1;
            E_bubble     = 1'b1;
            M_bubble     = 1'b1;
            halted       = 1'b1;
            stat_latched = r_stat_latched;
        end else begin
            F_stall      = w_load_use | w_ret_wait;
            D_stall      = w_load_use;
            D_bubble     = w_mispred | (w_ret_wait & !w_load_use);
            E_bubble     = w_mispred | w_load_use;
            M_bubble     = w_m_exc | w_w_exc;
            W_stall      = w_w_exc;
            set_cc       = (E_icode == IC_OPQ) && !w_m_exc && !w_w_exc;
            stat_latched = r_stat_latched;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_perf_stall_cnt;
    logic [31:0] r_perf_bubble_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_stall_cnt  <= 32'd0;
            r_perf_bubble_cnt <= 32'd0;
        end else if (r_stat_state == ST_RUN) begin
            if (F_stall) begin
                r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
            end
            if (D_bubble || E_bubble || M_bubble) begin
                r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = r_perf_stall_cnt;
    assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances, default ret stall length and length 1.
// Output vector order: {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted}.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] D_icode, E_icode, M_icode;
    logic [3:0] d_srcA, d_srcB, E_dstM;
    logic       e_Cnd;
    logic [3:0] m_stat, W_stat;

    logic       F_stall0, D_stall0, W_stall0, D_bubble0, E_bubble0, M_bubble0, set_cc0, halted0;
    logic [3:0] stat_latched0;
    logic       F_stall1, D_stall1, W_stall1, D_bubble1, E_bubble1, M_bubble1, set_cc1, halted1;
    logic [3:0] stat_latched1;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall0, perf_bubble0, perf_stall1, perf_bubble1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl #(.ICODE_W(4), .REG_W(4), .STAT_W(4), .RET_STALL_CYCLES(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall0), .D_stall(D_stall0), .W_stall(W_stall0),
        .D_bubble(D_bubble0), .E_bubble(E_bubble0), .M_bubble(M_bubble0),
        .set_cc(set_cc0), .halted(halted0), .stat_latched(stat_latched0)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall0), .perf_bubble_cnt(perf_bubble0)
`endif
    );

    hazard_ctrl #(.ICODE_W(4), .REG_W(4), .STAT_W(4), .RET_STALL_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall1), .D_stall(D_stall1), .W_stall(W_stall1),
        .D_bubble(D_bubble1), .E_bubble(E_bubble1), .M_bubble(M_bubble1),
        .set_cc(set_cc1), .halted(halted1), .stat_latched(stat_latched1)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall1), .perf_bubble_cnt(perf_bubble1)
`endif
    );

    logic [7:0] o0, o1;
    assign o0 = {F_stall0, D_stall0, W_stall0, D_bubble0, E_bubble0, M_bubble0, set_cc0, halted0};
    assign o1 = {F_stall1, D_stall1, W_stall1, D_bubble1, E_bubble1, M_bubble1, set_cc1, halted1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        D_icode = 4'd1;
        E_icode = 4'd1;
        M_icode = 4'd1;
        d_srcA  = 4'hF;
        d_srcB  = 4'hF;
        E_dstM  = 4'hF;
        e_Cnd   = 1'b1;
        m_stat  = 4'd1;
        W_stat  = 4'd1;
    endtask

    // Sample mid-cycle, compare both instances, then move to just after the next edge.
    task automatic cyc(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                       input logic [3:0] e_sl);
        @(negedge clk);
        $display("[%0t] %-10s o0=%b o1=%b stat_latched=%0d", $time, tag, o0, o1, stat_latched0);
        check({tag, ".dut0"}, 32'(o0), 32'(e0));
        check({tag, ".dut1"}, 32'(o1), 32'(e1));
        check({tag, ".slat"}, 32'(stat_latched0), 32'(e_sl));
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] O_NONE = 8'b00000000;
    localparam logic [7:0] O_LU   = 8'b11001000;
    localparam logic [7:0] O_MP   = 8'b00011000;
    localparam logic [7:0] O_RET  = 8'b10010000;
    localparam logic [7:0] O_CC   = 8'b00000010;
    localparam logic [7:0] O_MEXC = 8'b00000100;
    localparam logic [7:0] O_WEXC = 8'b00100100;
    localparam logic [7:0] O_HALT = 8'b11101101;

    initial begin
        rst_n = 1'b0;
        drive_nop();
        cyc("rst", O_NONE, O_NONE, 4'd0);
        rst_n = 1'b1;
        cyc("idle", O_NONE, O_NONE, 4'd1);

        // Load-use on srcA (mrmovq) and srcB (popq); RNONE never matches.
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        cyc("lu_a", O_LU, O_LU, 4'd1);
        drive_nop();
        E_icode = 4'd11; E_dstM = 4'd4; d_srcB = 4'd4;
        cyc("lu_b", O_LU, O_LU, 4'd1);
        drive_nop();
        E_icode = 4'd5; E_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        cyc("lu_rnone", O_NONE, O_NONE, 4'd1);

        // Mispredict, also with a wrong-path ret in D.
        drive_nop();
        E_icode = 4'd7; e_Cnd = 1'b0;
        cyc("mp", O_MP, O_MP, 4'd1);
        D_icode = 4'd9;
        cyc("mp_ret", O_MP, O_MP, 4'd1);
        drive_nop();
        cyc("mp_after", O_NONE, O_NONE, 4'd1);
        E_icode = 4'd7; e_Cnd = 1'b1;
        cyc("jxx_tkn", O_NONE, O_NONE, 4'd1);

        // Condition codes only for OPq with clean downstream status.
        drive_nop();
        E_icode = 4'd6;
        cyc("cc", O_CC, O_CC, 4'd1);
        m_stat = 4'd3;
        cyc("cc_mexc", O_MEXC, O_MEXC, 4'd1);

        // Plain ret: 3 stall cycles for dut0, 1 for dut1.
        drive_nop();
        D_icode = 4'd9;
        cyc("ret0", O_NONE, O_NONE, 4'd1);
        drive_nop();
        cyc("ret1", O_RET, O_RET, 4'd1);
        cyc("ret2", O_RET, O_NONE, 4'd1);
        cyc("ret3", O_RET, O_NONE, 4'd1);
        cyc("ret4", O_NONE, O_NONE, 4'd1);

        // Load-use with ret in D delays entry; load-use during RET_WAIT suppresses D_bubble.
        E_icode = 4'd11; E_dstM = 4'd4; d_srcB = 4'd4; D_icode = 4'd9;
        cyc("luret0", O_LU, O_LU, 4'd1);
        drive_nop();
        D_icode = 4'd9;
        cyc("luret1", O_NONE, O_NONE, 4'd1);
        drive_nop();
        cyc("luret2", O_RET, O_RET, 4'd1);
        E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
        cyc("luret3", O_LU, O_LU, 4'd1);
        drive_nop();
        cyc("luret4", O_RET, O_NONE, 4'd1);
        cyc("luret5", O_NONE, O_NONE, 4'd1);

        // Reset while the counter holds 2.
        D_icode = 4'd9;
        cyc("rret0", O_NONE, O_NONE, 4'd1);
        drive_nop();
        cyc("rret1", O_RET, O_RET, 4'd1);
        rst_n = 1'b0;
        cyc("rret2", O_NONE, O_NONE, 4'd0);
        rst_n = 1'b1;
        cyc("rret3", O_NONE, O_NONE, 4'd1);

        // Exception: detect, latch, stay frozen until reset.
        W_stat = 4'd3; E_icode = 4'd6;
        cyc("exc0", O_WEXC, O_WEXC, 4'd1);
        W_stat = 4'd1;
        cyc("exc1", O_HALT, O_HALT, 4'd3);
        E_icode = 4'd7; e_Cnd = 1'b0; D_icode = 4'd9;
        cyc("exc2", O_HALT, O_HALT, 4'd3);
        drive_nop();
        W_stat = 4'd4;
        cyc("exc3", O_HALT, O_HALT, 4'd3);
        drive_nop();
        rst_n = 1'b0;
        cyc("exc_rst", O_NONE, O_NONE, 4'd0);
        rst_n = 1'b1;
        cyc("exc_run", O_NONE, O_NONE, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
